// File: rtl/sar_scan_sequencer.sv
// rtl/sar_scan_sequencer.sv - multi-channel scan sequencer for the 8-bit SAR ADC controller
// Walks enabled mux channels in ascending order: settle, convert, gap; one-shot or continuous.
module sar_scan_sequencer #(
    parameter int NCH     = 4,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 32,
    localparam int CHW    = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           continuous,
    input  logic           abort,
    input  logic [NCH-1:0] ch_enable,
    input  logic           adc_valid,
    input  logic [7:0]     adc_result,
    output logic           adc_go,
    output logic [CHW-1:0] mux_sel,
    output logic           busy,
    output logic           data_valid,
    output logic [CHW-1:0] data_ch,
    output logic [7:0]     data_out,
    output logic           done,
    output logic           timeout_err
);
    localparam int CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONV, S_GAP} state_t;

    state_t         r_state, w_state_nx;
    logic [CW-1:0]  r_cnt, w_cnt_nx;
    logic [NCH-1:0] r_en_q, w_en_nx;
    logic           r_cont_q, w_cont_nx;
    logic [CHW-1:0] r_mux_sel, w_mux_nx;
    logic           r_data_valid, w_dv_nx;
    logic [CHW-1:0] r_data_ch, w_data_ch_nx;
    logic [7:0]     r_data_out, w_data_out_nx;
    logic           r_done, w_done_nx;
    logic           r_timeout_err, w_terr_nx;
    logic [CHW:0]   w_first, w_next, w_wrap;

    // Returns {found, index} of the lowest set bit, optionally only above cur.
    function automatic logic [CHW:0] f_pick(input logic [NCH-1:0] mask,
                                            input logic [CHW-1:0] cur,
                                            input logic           above);
        logic [CHW:0] res;
        res = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (!above || (CHW'(i) > cur))) begin
                res = {1'b1, CHW'(i)};
            end
        end
        return res;
    endfunction

    assign w_first = f_pick(ch_enable, '0, 1'b0);
    assign w_next  = f_pick(r_en_q, r_mux_sel, 1'b1);
    assign w_wrap  = f_pick(r_en_q, '0, 1'b0);

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_en_nx       = r_en_q;
        w_cont_nx     = r_cont_q;
        w_mux_nx      = r_mux_sel;
        w_dv_nx       = 1'b0;
        w_data_ch_nx  = r_data_ch;
        w_data_out_nx = r_data_out;
        w_done_nx     = 1'b0;
        w_terr_nx     = r_timeout_err;
        if (abort) begin
            // Abort wins over everything, including a completing conversion.
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (|ch_enable)) begin
                        w_en_nx    = ch_enable;
                        w_cont_nx  = continuous;
                        w_terr_nx  = 1'b0;
                        w_mux_nx   = w_first[CHW-1:0];
                        w_cnt_nx   = '0;
                        w_state_nx = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CW'(SETTLE - 1)) begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_CONV;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                S_CONV: begin
                    if (adc_valid) begin
                        w_data_out_nx = adc_result;
                        w_data_ch_nx  = r_mux_sel;
                        w_dv_nx       = 1'b1;
                        w_cnt_nx      = '0;
                        w_state_nx    = S_GAP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        w_terr_nx  = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (w_next[CHW]) begin
                        w_mux_nx   = w_next[CHW-1:0];
                        w_state_nx = S_SETTLE;
                    end else if (r_cont_q) begin
                        w_mux_nx   = w_wrap[CHW-1:0];
                        w_state_nx = S_SETTLE;
                    end else begin
                        w_done_nx  = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_en_q        <= '0;
            r_cont_q      <= 1'b0;
            r_mux_sel     <= '0;
            r_data_valid  <= 1'b0;
            r_data_ch     <= '0;
            r_data_out    <= '0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_en_q        <= w_en_nx;
            r_cont_q      <= w_cont_nx;
            r_mux_sel     <= w_mux_nx;
            r_data_valid  <= w_dv_nx;
            r_data_ch     <= w_data_ch_nx;
            r_data_out    <= w_data_out_nx;
            r_done        <= w_done_nx;
            r_timeout_err <= w_terr_nx;
        end
    end

    // adc_go low outside CONV also holds the SAR in its wait state.
    assign adc_go      = (r_state == S_CONV);
    assign busy        = (r_state != S_IDLE);
    assign mux_sel     = r_mux_sel;
    assign data_valid  = r_data_valid;
    assign data_ch     = r_data_ch;
    assign data_out    = r_data_out;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_sar_scan_sequencer.sv
// tb/tb_sar_scan_sequencer.sv - scoreboard bench for sar_scan_sequencer
// Stimulus pushes expected (channel, result) pairs; a negedge monitor pops and compares.
module tb_sar_scan_sequencer;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           continuous = 1'b0;
    logic           abort = 1'b0;
    logic [NCH-1:0] ch_enable = '0;
    logic           adc_valid;
    logic [7:0]     adc_result;
    logic           adc_go;
    logic [CHW-1:0] mux_sel;
    logic           busy;
    logic           data_valid;
    logic [CHW-1:0] data_ch;
    logic [7:0]     data_out;
    logic           done;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int done_cnt = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  sar_q[$];
    bit          sar_en = 1'b1;
    int          sar_cnt = 0;
    logic        m_valid = 1'b0;
    logic [7:0]  m_result = '0;
    logic        man_valid = 1'b0;
    logic [7:0]  man_result = '0;

    assign adc_valid  = sar_en ? m_valid : man_valid;
    assign adc_result = sar_en ? m_result : man_result;

    sar_scan_sequencer #(.NCH(NCH), .SETTLE(3), .TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .abort(abort), .ch_enable(ch_enable), .adc_valid(adc_valid),
        .adc_result(adc_result), .adc_go(adc_go), .mux_sel(mux_sel),
        .busy(busy), .data_valid(data_valid), .data_ch(data_ch),
        .data_out(data_out), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // SAR model: result valid on the 4th negedge of adc_go high.
    always @(negedge clk) begin
        if (!sar_en || !adc_go) begin
            sar_cnt = 0;
            m_valid = 1'b0;
        end else begin
            sar_cnt++;
            if (sar_cnt == 4) begin
                m_valid  = 1'b1;
                m_result = (sar_q.size() > 0) ? sar_q.pop_front() : 8'hFF;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [15:0] e;
        if (rst_n && data_valid) begin
            dv_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected got ch=%0d data=%02h required none", data_ch, data_out);
            end else begin
                e = exp_q.pop_front();
                if ({8'(data_ch), data_out} !== e) begin
                    errors++;
                    $display("FAIL scoreboard got ch=%0d data=%02h required ch=%0d data=%02h",
                             data_ch, data_out, e[15:8], e[7:0]);
                end
            end
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic expire(input string nm);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", nm);
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        sar_q.push_back(d);
        exp_q.push_back({8'(ch), d});
    endtask

    task automatic do_start(input logic [NCH-1:0] en, input logic cont);
        @(negedge clk);
        ch_enable  = en;
        continuous = cont;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_go(input logic lvl);
        int n = 0;
        while (adc_go !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) expire("wait_go");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) expire("wait_idle");
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_adc_go"}, adc_go, 0);
        chk({pfx, "_data_valid"}, data_valid, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_timeout_err"}, timeout_err, 0);
        chk({pfx, "_mux_sel"}, mux_sel, 0);
        chk({pfx, "_data_ch"}, data_ch, 0);
        chk({pfx, "_data_out"}, data_out, 0);
    endtask

    initial begin
        int d0, v0, n, t, lowcnt, hi;
        bit seen;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Two-channel one-shot scan, mask changes while busy are ignored.
        push(1, 8'h5A);
        push(3, 8'hC3);
        d0 = done_cnt;
        do_start(4'b1010, 1'b0);
        ch_enable = 4'b0101;
        chk("t1_first_mux", mux_sel, 1);
        chk("t1_busy", busy, 1);
        chk("t1_go_edge0", adc_go, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t1_go_settle", adc_go, 0);
        end
        @(negedge clk);
        chk("t1_go_after_settle", adc_go, 1);
        wait_go(1'b0);
        lowcnt = 0;
        while (!adc_go && lowcnt < 50) begin
            lowcnt++;
            @(negedge clk);
        end
        chk("t1_go_low_between", lowcnt, 4);
        chk("t1_second_mux", mux_sel, 3);
        wait_idle();
        chk("t1_done_once", done_cnt, d0 + 1);
        chk("t1_queue_drained", exp_q.size(), 0);
        chk("t1_data_out_held", data_out, 8'hC3);
        chk("t1_data_ch_held", data_ch, 3);

        // Start with an empty mask does nothing.
        d0 = done_cnt;
        v0 = dv_cnt;
        seen = 1'b0;
        @(negedge clk);
        ch_enable = '0;
        start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (busy || adc_go) seen = 1'b1;
        end
        start = 1'b0;
        chk("t2_no_activity", seen, 0);
        chk("t2_no_data_valid", dv_cnt, v0);
        chk("t2_no_done", done_cnt, d0);

        // Continuous single channel, then abort.
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        d0 = done_cnt;
        do_start(4'b0001, 1'b1);
        n = 0;
        t = 0;
        while (n < 3 && t < 500) begin
            @(negedge clk);
            t++;
            if (data_valid) n++;
        end
        if (n < 3) expire("t3_results");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t3_abort_busy", busy, 0);
        chk("t3_abort_go", adc_go, 0);
        repeat (20) @(negedge clk);
        chk("t3_still_idle", busy, 0);
        chk("t3_no_done", done_cnt, d0);
        chk("t3_queue_drained", exp_q.size(), 0);

        // Conversion timeout, then a fresh start clears the flag.
        sar_en = 1'b0;
        d0 = done_cnt;
        v0 = dv_cnt;
        do_start(4'b0001, 1'b0);
        wait_go(1'b1);
        hi = 0;
        while (adc_go && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        chk("t4_go_high_cycles", hi, 32);
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_idle", busy, 0);
        repeat (3) @(negedge clk);
        chk("t4_no_done", done_cnt, d0);
        chk("t4_no_data_valid", dv_cnt, v0);
        sar_en = 1'b1;
        push(2, 8'h9C);
        do_start(4'b0100, 1'b0);
        chk("t4_err_cleared", timeout_err, 0);
        wait_idle();
        chk("t4_done", done_cnt, d0 + 1);
        chk("t4_data_out", data_out, 8'h9C);

        // Abort coinciding with adc_valid discards the result.
        sar_en = 1'b0;
        d0 = done_cnt;
        v0 = dv_cnt;
        do_start(4'b1000, 1'b0);
        wait_go(1'b1);
        @(negedge clk);
        man_valid  = 1'b1;
        man_result = 8'h77;
        abort      = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        abort     = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_go", adc_go, 0);
        repeat (5) @(negedge clk);
        chk("t5_no_data_valid", dv_cnt, v0);
        chk("t5_no_done", done_cnt, d0);
        chk("t5_data_out_kept", data_out, 8'h9C);
        chk("t5_data_ch_kept", data_ch, 2);
        sar_en = 1'b1;

        // Asynchronous reset mid-conversion, then a clean scan.
        do_start(4'b0011, 1'b0);
        wait_go(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 8'hA1);
        push(1, 8'hB2);
        d0 = done_cnt;
        do_start(4'b0011, 1'b0);
        wait_idle();
        chk("t6_done", done_cnt, d0 + 1);
        chk("t6_queue_drained", exp_q.size(), 0);
        chk("t6_data_out", data_out, 8'hB2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
